// File: rtl/gf2_karatsuba_mult_seq.sv
// Sequential one-level Karatsuba GF(2) polynomial multiplier sharing one H x H carry-less core.
// Define KA_REDUCE_EN to fold the product modulo x^WIDTH + x^TRI_K + 1 in an extra RED state.
module gf2_karatsuba_mult_seq #(
  parameter int WIDTH = 233,
  parameter int TRI_K = 74
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef KA_REDUCE_EN
  output logic [WIDTH-1:0] y,
`else
  output logic [2*WIDTH-2:0] y,
`endif
  output logic             busy
);

  localparam int H   = (WIDTH + 1) / 2;
  localparam int PPW = 2 * H - 1;
  localparam int PW  = 2 * WIDTH - 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] P_LO  = 3'd1;
  localparam logic [2:0] P_HI  = 3'd2;
  localparam logic [2:0] P_MID = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
`ifdef KA_REDUCE_EN
  localparam logic [2:0] RED   = 3'd5;
`else
  // TRI_K only shapes the reduction fold, which this build leaves out.
  localparam int unused_tri_k = TRI_K;
`endif

  logic [2:0]       state;
  logic [WIDTH-1:0] a_r, b_r;
  logic [PPW-1:0]   p0, p1, core_p, mid;
  logic [H-1:0]     a_lo, a_hi, b_lo, b_hi, core_a, core_b;
  logic [PW-1:0]    prod_full;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  // For odd WIDTH the high half is one bit short; the cast zero-fills its top bit.
  assign a_lo = a_r[H-1:0];
  assign b_lo = b_r[H-1:0];
  assign a_hi = H'(a_r >> H);
  assign b_hi = H'(b_r >> H);

  always_comb begin
    core_a = a_lo ^ a_hi;
    core_b = b_lo ^ b_hi;
    case (state)
      P_LO: begin
        core_a = a_lo;
        core_b = b_lo;
      end
      P_HI: begin
        core_a = a_hi;
        core_b = b_hi;
      end
      default: ;
    endcase
  end

  always_comb begin
    core_p = '0;
    for (int i = 0; i < H; i++)
      if (core_a[i]) core_p = core_p ^ (PPW'(core_b) << i);
  end

  // Karatsuba combine: core_p holds P2 during P_MID, so mid is the true middle term.
  assign mid       = p0 ^ p1 ^ core_p;
  assign prod_full = PW'(p0) ^ (PW'(mid) << H) ^ (PW'(p1) << (2 * H));

`ifdef KA_REDUCE_EN
  localparam int DW = 2 * WIDTH;
  logic [PW-1:0]    prod_r;
  logic [DW-1:0]    hi1, s1, hi2;
  logic [WIDTH-1:0] red_y;

  // Two folds suffice: after the first, the overflow is below TRI_K bits wide, and TRI_K < WIDTH/2.
  always_comb begin
    hi1   = DW'(prod_r) >> WIDTH;
    s1    = DW'(prod_r[WIDTH-1:0]) ^ hi1 ^ (hi1 << TRI_K);
    hi2   = s1 >> WIDTH;
    red_y = s1[WIDTH-1:0] ^ WIDTH'(hi2) ^ WIDTH'(hi2 << TRI_K);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      p0    <= '0;
      p1    <= '0;
      y     <= '0;
`ifdef KA_REDUCE_EN
      prod_r <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            state <= P_LO;
          end
        end
        P_LO: begin
          p0    <= core_p;
          state <= P_HI;
        end
        P_HI: begin
          p1    <= core_p;
          state <= P_MID;
        end
        P_MID: begin
`ifdef KA_REDUCE_EN
          prod_r <= prod_full;
          state  <= RED;
`else
          y      <= prod_full;
          state  <= DONE;
`endif
        end
`ifdef KA_REDUCE_EN
        RED: begin
          y     <= red_y;
          state <= DONE;
        end
`endif
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
